reg_wb_arbiter: RTL and testbench

// - Write-back stage directly upstream of the 32x32 register file's single write port (wen/waddr/wdata).
// - Merges results from two producers into one registered write per cycle:
//   - ALU path: single-cycle results.
//   - MEM path: load / multi-cycle results.
// - Each source has its own FIFO buffer; round-robin arbitration picks between them.

---
 rtl/reg_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-back stage in front of the register file's single write port.
// Two producers (ALU and MEM) each feed a small FIFO. A round-robin arbiter picks
// one head per cycle, and that head is registered onto rf_wen/rf_waddr/rf_wdata.
// Writes addressed to x0 are accepted but dropped before they reach a FIFO.
// Optional feature macro: WB_BYPASS_EN adds a combinational read-bypass for two
// read ports, so a reader sees the write that lands at the coming edge.
module reg_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_waddr,
    input  logic [DATA_WIDTH-1:0] alu_wdata,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0] byp_raddr1,
    input  logic [ADDR_WIDTH-1:0] byp_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    output logic [DATA_WIDTH-1:0] byp_rdata1,
    output logic [DATA_WIDTH-1:0] byp_rdata2,
`endif
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_busy
);

    // One extra pointer bit distinguishes full from empty when the indices match.
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

    // Index 0 is the ALU source, index 1 is the MEM source.
    logic [1:0]            in_valid;
    logic [1:0]            in_ready;
    logic [1:0]            fifo_empty;
    logic [1:0]            fifo_full;
    logic [1:0]            pop;
    logic [ADDR_WIDTH-1:0] in_waddr   [2];
    logic [DATA_WIDTH-1:0] in_wdata   [2];
    logic [ADDR_WIDTH-1:0] head_waddr [2];
    logic [DATA_WIDTH-1:0] head_wdata [2];

    src_t                  last_grant_reg;

    assign in_valid    = {mem_valid, alu_valid};
    assign in_waddr[0] = alu_waddr;
    assign in_waddr[1] = mem_waddr;
    assign in_wdata[0] = alu_wdata;
    assign in_wdata[1] = mem_wdata;
    assign alu_ready   = in_ready[0];
    assign mem_ready   = in_ready[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem_array [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic             push;

            assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign fifo_full[gi]  = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                                    (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
            // Ready looks only at full (and reset), never at a same-cycle pop.
            assign in_ready[gi]   = !fifo_full[gi] && !rst;
            // x0 writes complete the handshake but are never stored.
            assign push           = in_valid[gi] && in_ready[gi] && (in_waddr[gi] != '0);

            // Storage for buffered entries; no reset needed, pointers define validity.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_array[wr_ptr_reg[IDX_W-1:0]] <= {in_waddr[gi], in_wdata[gi]};
                end
            end

            // Pointer update; push and pop in the same cycle leave occupancy unchanged.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                end
            end

            assign {head_waddr[gi], head_wdata[gi]} = mem_array[rd_ptr_reg[IDX_W-1:0]];
        end
    endgenerate

    // Round-robin choice: a lone non-empty source always wins; on a tie the source
    // opposite the last tie winner goes. last_grant starts at MEM so ALU wins the first tie.
    always_comb begin
        pop = 2'b00;
        if (!fifo_empty[0] && (fifo_empty[1] || last_grant_reg == SRC_MEM)) begin
            pop[0] = 1'b1;
        end else if (!fifo_empty[1]) begin
            pop[1] = 1'b1;
        end
    end

    // Output register and tie-history update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen         <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            last_grant_reg <= SRC_MEM;
        end else begin
            rf_wen <= |pop;
            if (|pop) begin
                rf_waddr <= pop[1] ? head_waddr[1] : head_waddr[0];
                rf_wdata <= pop[1] ? head_wdata[1] : head_wdata[0];
            end
            if (!fifo_empty[0] && !fifo_empty[1]) begin
                last_grant_reg <= pop[1] ? SRC_MEM : SRC_ALU;
            end
        end
    end

    assign wb_busy = !fifo_empty[0] || !fifo_empty[1] || rf_wen;

`ifdef WB_BYPASS_EN
    // Forward the write landing at the coming edge to readers of the same register.
    always_comb begin
        byp_rdata1 = rf_rdata1;
        byp_rdata2 = rf_rdata2;
        if (rf_wen && rf_waddr == byp_raddr1 && byp_raddr1 != '0) begin
            byp_rdata1 = rf_wdata;
        end
        if (rf_wen && rf_waddr == byp_raddr2 && byp_raddr2 != '0) begin
            byp_rdata2 = rf_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: scoreboard bench for reg_wb_arbiter.
// The reference model is one queue per source: each accepted non-x0 entry is
// queued, and every register-file write must match the head of one of the queues.
// Directed phases cover reset, latency, x0 drop, contention order, full, and
// reset in mid-operation. A randomized phase follows, with the bypass checked
// when WB_BYPASS_EN is defined.
module tb_reg_wb_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_waddr, mem_waddr;
    logic [DW-1:0] alu_wdata, mem_wdata;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          wb_busy;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] byp_raddr1, byp_raddr2;
    logic [DW-1:0] rf_rdata1, rf_rdata2, byp_rdata1, byp_rdata2;
`endif

    reg_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
`ifdef WB_BYPASS_EN
        .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .byp_rdata1(byp_rdata1), .byp_rdata2(byp_rdata2),
`endif
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_busy(wb_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } log_t;

    ent_t alu_q[$];
    ent_t mem_q[$];
    log_t wr_log[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    logic last_mem_ready;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write must be the oldest outstanding entry of one source.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && rf_wen) begin
            e = '{rf_waddr, rf_wdata};
            wr_log.push_back('{cyc, rf_wdata});
            checks++;
            if (alu_q.size() > 0 && alu_q[0] == e) begin
                void'(alu_q.pop_front());
                passes++;
                $display("wb write addr=%0d data=%08h (alu)", rf_waddr, rf_wdata);
            end else if (mem_q.size() > 0 && mem_q[0] == e) begin
                void'(mem_q.pop_front());
                passes++;
                $display("wb write addr=%0d data=%08h (mem)", rf_waddr, rf_wdata);
            end else begin
                $display("FAIL wb_write: got addr=%0d data=%08h, required head of alu(%0d left) or mem(%0d left)",
                         rf_waddr, rf_wdata, alu_q.size(), mem_q.size());
            end
        end
    end

    // One cycle of stimulus; entries the DUT accepts are queued into the model.
    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        @(negedge clk);
        #1;
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        mem_valid = mv; mem_waddr = ma; mem_wdata = md;
        #1;
        last_mem_ready = mem_ready;
        if (alu_valid && alu_ready && alu_waddr != '0) alu_q.push_back('{alu_waddr, alu_wdata});
        if (mem_valid && mem_ready && mem_waddr != '0) mem_q.push_back('{mem_waddr, mem_wdata});
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int zero_run;
        int max_zero_run;
        logic seen_full;
        logic [DW-1:0] exp_seq [8];
        rst = 1'b1;
        alu_valid = 0; alu_waddr = 0; alu_wdata = 0;
        mem_valid = 0; mem_waddr = 0; mem_wdata = 0;
`ifdef WB_BYPASS_EN
        byp_raddr1 = 0; byp_raddr2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
`endif
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_rf_wen", rf_wen, 0);
        check("rst_wb_busy", wb_busy, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        #1 rst = 1'b0;
        @(negedge clk); #2;
        check("rel_alu_ready", alu_ready, 1);
        check("rel_mem_ready", mem_ready, 1);

        // Single ALU write: enqueue edge, then pop edge, then one-cycle pulse
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0);
        idle(); check("lat_wen_early", rf_wen, 0);
        idle();
        check("lat_wen", rf_wen, 1);
        check("lat_waddr", rf_waddr, 5);
        check("lat_wdata", rf_wdata, 32'h1234_5678);
        idle(); check("lat_wen_pulse", rf_wen, 0);

        // x0 drop
        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, '0);
        check("x0_ready", alu_ready, 1);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("x0_no_wen", rf_wen, 0);
            check("x0_not_busy", wb_busy, 0);
        end

        // Contention: strict alternation starting with ALU, no gaps
        wr_log.delete();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, AW'(i), DW'(i), 1'b1, AW'(i + 10), DW'(i + 10));
            exp_seq[2*(i-1)]   = DW'(i);
            exp_seq[2*(i-1)+1] = DW'(i + 10);
        end
        repeat (10) idle();
        check("cont_count", wr_log.size(), 8);
        for (int k = 0; k < 8 && k < wr_log.size(); k++) begin
            check("cont_data", wr_log[k].d, exp_seq[k]);
            if (k > 0) check("cont_gap", wr_log[k].c - wr_log[k-1].c, 1);
        end

        // Full: both sources stream every cycle so MEM fills; ready must recover quickly
        seen_full = 1'b0; zero_run = 0; max_zero_run = 0;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b1, AW'($urandom_range(1, 31)), $urandom);
            if (!last_mem_ready) begin
                seen_full = 1'b1;
                zero_run++;
                if (zero_run > max_zero_run) max_zero_run = zero_run;
            end else begin
                zero_run = 0;
            end
        end
        check("full_seen", seen_full, 1);
        check("full_recover", max_zero_run <= 2, 1);
        for (int i = 0; i < 20 && (alu_q.size() + mem_q.size() > 0 || wb_busy); i++) idle();
        check("full_drained_alu", alu_q.size(), 0);
        check("full_drained_mem", mem_q.size(), 0);

        // Reset in mid-operation discards everything; rf_wen drops at once
        for (int i = 0; i < 3; i++)
            drive(1'b1, AW'(i + 1), $urandom, 1'b1, AW'(i + 20), $urandom);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_wen", rf_wen, 0);
        check("mid_rst_busy", wb_busy, 0);
        alu_valid = 0; mem_valid = 0;
        alu_q.delete(); mem_q.delete();
        @(negedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("post_rst_wen", rf_wen, 0);
        end

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 6, AW'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 9) < 6, AW'($urandom_range(0, 31)), $urandom);
        end
        for (int i = 0; i < 40 && (alu_q.size() + mem_q.size() > 0 || wb_busy); i++) idle();
        check("rand_alu_empty", alu_q.size(), 0);
        check("rand_mem_empty", mem_q.size(), 0);
        check("rand_not_busy", wb_busy, 0);

`ifdef WB_BYPASS_EN
        drive(1'b1, 5'd7, 32'hAA, 1'b0, '0, '0);
        idle(); idle();
        check("byp_wen", rf_wen, 1);
        byp_raddr1 = 5'd7; rf_rdata1 = 32'h55; byp_raddr2 = 5'd3; rf_rdata2 = 32'h66;
        #1;
        check("byp1_hit", byp_rdata1, 32'hAA);
        check("byp2_miss", byp_rdata2, 32'h66);
        byp_raddr1 = 5'd0; byp_raddr2 = 5'd7;
        #1;
        check("byp1_x0", byp_rdata1, 32'h55);
        check("byp2_hit", byp_rdata2, 32'hAA);
        idle();
        check("byp_idle", byp_rdata2, 32'h66);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
